// File: rtl/wb_stream_pkg.sv
// wb_stream_pkg: shared FSM state encoding and Wishbone cycle-type constants
// for the stream reader controller (wb_stream_reader_ctrl).
package wb_stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_stream_reader_ctrl.sv
// wb_stream_reader_ctrl: Wishbone burst-write master that drains a show-ahead
// stream FIFO into a linear memory buffer in bursts of up to burst_size words.
//
// Ports:
//   wb_clk_i, wb_rst_n_i     clock, asynchronous active-low reset
//   wbm_*                    Wishbone master (write-only, linear incrementing bursts)
//   fifo_d, fifo_rd, fifo_cnt show-ahead FIFO head word, pop strobe, fill level
//   enable                   start-of-buffer request pulse
//   busy, irq, tx_cnt        transfer in progress, completion pulse, words written
//   start_adr, buf_size, burst_size  configuration, sampled live
//   err                      sticky bus-error flag (only with WB_STREAM_READER_ERR_EN)
//
// Build option: define WB_STREAM_READER_ERR_EN to abort the buffer on wbm_err_i
// and expose the err output; otherwise wbm_err_i is ignored and stalls like rty.
module wb_stream_reader_ctrl
    import wb_stream_pkg::*;
#(
    parameter int WB_AW         = 32,
    parameter int WB_DW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    output logic [WB_AW-1:0]     wbm_adr_o,
    output logic [WB_DW-1:0]     wbm_dat_o,
    output logic [WB_DW/8-1:0]   wbm_sel_o,
    output logic                 wbm_we_o,
    output logic                 wbm_cyc_o,
    output logic                 wbm_stb_o,
    output logic [2:0]           wbm_cti_o,
    output logic [1:0]           wbm_bte_o,
    input  logic [WB_DW-1:0]     wbm_dat_i,
    input  logic                 wbm_ack_i,
    input  logic                 wbm_err_i,
    input  logic                 wbm_rty_i,
    input  logic [WB_DW-1:0]     fifo_d,
    output logic                 fifo_rd,
    input  logic [FIFO_AW:0]     fifo_cnt,
    input  logic                 enable,
    output logic                 busy,
    output logic                 irq,
`ifdef WB_STREAM_READER_ERR_EN
    output logic                 err,
`endif
    output logic [WB_AW-1:0]     tx_cnt,
    input  logic [WB_AW-1:0]     start_adr,
    input  logic [WB_AW-1:0]     buf_size,
    input  logic [WB_AW-1:0]     burst_size
);

    localparam int BW = $clog2(MAX_BURST_LEN + 1);

    if (FIFO_AW < 1) begin : g_bad_fifo_aw
        $error("FIFO_AW must be greater than 0");
    end

    state_t           state_q, state_d;
    logic             busy_q, busy_d;
    logic             irq_q, irq_d;
    logic [WB_AW-1:0] tx_q, tx_d;
    logic [WB_AW-1:0] blen_q, blen_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [WB_AW-1:0] buf_words, rem, bsz, blen, tx_inc;
    logic             in_burst, last, ack, done;
`ifdef WB_STREAM_READER_ERR_EN
    logic             err_q, err_d, abort;
`endif
    logic             unused;

    assign buf_words = {2'b00, buf_size[WB_AW-1:2]};
    assign rem       = buf_words - tx_q;
    assign bsz       = (burst_size == '0) ? WB_AW'(1) : burst_size;
    assign blen      = (bsz < rem) ? bsz : rem;
    assign tx_inc    = tx_q + 1'b1;
    assign in_burst  = state_q == S_BURST;
    assign last      = WB_AW'(bcnt_q) == blen_q - 1'b1;
    assign done      = tx_inc == buf_words;
`ifdef WB_STREAM_READER_ERR_EN
    // A simultaneous err wins over ack so the failing word is never counted.
    assign abort     = in_burst & wbm_err_i;
    assign ack       = in_burst & wbm_ack_i & ~wbm_err_i;
    assign err       = err_q;
    assign unused    = ^{wbm_dat_i, wbm_rty_i, buf_size[1:0]};
`else
    assign ack       = in_burst & wbm_ack_i;
    assign unused    = ^{wbm_dat_i, wbm_rty_i, wbm_err_i, buf_size[1:0]};
`endif

    assign wbm_adr_o = start_adr + (tx_q << 2);
    assign wbm_dat_o = fifo_d;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b1;
    assign wbm_cyc_o = in_burst;
    assign wbm_stb_o = in_burst;
    assign wbm_cti_o = in_burst ? (last ? CTI_EOB : CTI_INC) : CTI_CLASSIC;
    assign wbm_bte_o = BTE_LINEAR;
    assign fifo_rd   = ack;
    assign busy      = busy_q;
    assign irq       = irq_q;
    assign tx_cnt    = tx_q;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        irq_d   = 1'b0;
        tx_d    = tx_q;
        blen_d  = blen_q;
        bcnt_d  = bcnt_q;
`ifdef WB_STREAM_READER_ERR_EN
        err_d   = err_q;
`endif
        if (state_q == S_IDLE && enable && buf_words != '0) begin
            state_d = S_WAIT;
            busy_d  = 1'b1;
            tx_d    = '0;
            bcnt_d  = '0;
`ifdef WB_STREAM_READER_ERR_EN
            err_d   = 1'b0;
`endif
        end
        // Entering a burst only with the whole burst already buffered keeps the FIFO from underflowing.
        if (state_q == S_WAIT && WB_AW'(fifo_cnt) >= blen) begin
            state_d = S_BURST;
            blen_d  = blen;
            bcnt_d  = '0;
        end
        if (ack) begin
            tx_d   = tx_inc;
            bcnt_d = bcnt_q + 1'b1;
            if (last) begin
                state_d = done ? S_IDLE : S_WAIT;
                busy_d  = ~done;
                irq_d   = done;
            end
        end
`ifdef WB_STREAM_READER_ERR_EN
        if (abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            irq_d   = 1'b1;
            err_d   = 1'b1;
        end
`endif
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            irq_q   <= 1'b0;
            tx_q    <= '0;
            blen_q  <= '0;
            bcnt_q  <= '0;
`ifdef WB_STREAM_READER_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            irq_q   <= irq_d;
            tx_q    <= tx_d;
            blen_q  <= blen_d;
            bcnt_q  <= bcnt_d;
`ifdef WB_STREAM_READER_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_wb_stream_reader_ctrl.sv
// tb_wb_stream_reader_ctrl: directed table-driven bench for wb_stream_reader_ctrl
// with a FIFO model, an ack/rty/err slave model and hand-computed expectations.
module tb_wb_stream_reader_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic [31:0] fifo_d;
    logic        fifo_rd;
    logic [4:0]  fifo_cnt;
    logic        enable, busy, irq;
    logic [31:0] tx_cnt, start_adr, buf_size, burst_size;
`ifdef WB_STREAM_READER_ERR_EN
    logic        err;
`endif

    logic        ack_en, err_en, rty;
    logic [7:0]  rd_ptr = '0;
    logic [7:0]  wr_ptr;
    logic [31:0] mem [256];

    int          tests, fails;
    int          beat_idx, irq_cnt, n;
    logic [7:0]  exp_ptr, r0;
    logic [15:0] cur_mask;
    logic [31:0] last_adr, a0, d0;

    typedef struct {
        logic [31:0] bsize;
        logic [31:0] bst;
        int          beats;
        logic [15:0] eob_mask;
        logic [31:0] last_off;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    assign wbm_ack_i = ack_en & wbm_cyc_o & wbm_stb_o;
    assign wbm_err_i = err_en & wbm_cyc_o;
    assign wbm_rty_i = rty & wbm_cyc_o;
    assign fifo_d    = mem[rd_ptr];
    assign fifo_cnt  = 5'(wr_ptr - rd_ptr);

    always @(posedge clk) if (fifo_rd) rd_ptr <= rd_ptr + 8'd1;

    wb_stream_reader_ctrl dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_cti_o  (wbm_cti_o),
        .wbm_bte_o  (wbm_bte_o),
        .wbm_dat_i  (32'h0),
        .wbm_ack_i  (wbm_ack_i),
        .wbm_err_i  (wbm_err_i),
        .wbm_rty_i  (wbm_rty_i),
        .fifo_d     (fifo_d),
        .fifo_rd    (fifo_rd),
        .fifo_cnt   (fifo_cnt),
        .enable     (enable),
        .busy       (busy),
        .irq        (irq),
`ifdef WB_STREAM_READER_ERR_EN
        .err        (err),
`endif
        .tx_cnt     (tx_cnt),
        .start_adr  (start_adr),
        .buf_size   (buf_size),
        .burst_size (burst_size)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: sample/score at negedge, then return just after the posedge.
    task automatic step();
        @(negedge clk);
        if (irq) irq_cnt++;
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            chk("beat_adr", wbm_adr_o, start_adr + 32'(beat_idx * 4));
            chk("beat_dat", wbm_dat_o, {24'hC0DE00, exp_ptr});
            chk("beat_cti", 32'(wbm_cti_o), cur_mask[beat_idx[3:0]] ? 32'd7 : 32'd2);
            chk("beat_fifo_rd", 32'(fifo_rd), 32'd1);
            last_adr = wbm_adr_o;
            beat_idx++;
            exp_ptr++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_en();
        enable = 1'b1;
        step();
        enable = 1'b0;
    endtask

    task automatic setup(input logic [31:0] bsz, input logic [31:0] bst, input logic [15:0] mask, input int words);
        buf_size   = bsz;
        burst_size = bst;
        cur_mask   = mask;
        wr_ptr     = rd_ptr + 8'(words);
        beat_idx   = 0;
        exp_ptr    = rd_ptr;
        irq_cnt    = 0;
    endtask

    task automatic run_buffer(input logic [31:0] bsz, input logic [31:0] bst, input int beats,
                              input logic [15:0] mask, input logic [31:0] last_off);
        setup(bsz, bst, mask, 16);
        ack_en = 1'b1;
        pulse_en();
        n = 0;
        while (irq_cnt == 0 && n < ((beats == 0) ? 20 : 400)) begin
            step();
            n++;
        end
        chk("beats", 32'(beat_idx), 32'(beats));
        chk("irq_count", 32'(irq_cnt), (beats == 0) ? 32'd0 : 32'd1);
        chk("busy_end", 32'(busy), 32'd0);
        chk("irq_one_cycle", 32'(irq), 32'd0);
        chk("cti_idle", 32'(wbm_cti_o), 32'd0);
        if (beats != 0) begin
            chk("tx_cnt_end", tx_cnt, 32'(beats));
            chk("last_adr", last_adr, start_adr + last_off);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        for (int i = 0; i < 256; i++) mem[i] = {24'hC0DE00, 8'(i)};
        rst_n = 1'b0; enable = 1'b0; ack_en = 1'b0; err_en = 1'b0; rty = 1'b0;
        wr_ptr = '0; start_adr = 32'h0000_4000; buf_size = '0; burst_size = '0;
        beat_idx = 0; irq_cnt = 0; exp_ptr = '0; cur_mask = '0; last_adr = '0;

        vecs[0] = '{32'd64, 32'd4,  16, 16'h8888, 32'h3C};
        vecs[1] = '{32'd40, 32'd4,  10, 16'h0288, 32'h24};
        vecs[2] = '{32'd12, 32'd0,   3, 16'h0007, 32'h08};
        vecs[3] = '{32'd20, 32'd16,  5, 16'h0010, 32'h10};
        vecs[4] = '{32'd16, 32'd1,   4, 16'h000F, 32'h0C};
        vecs[5] = '{32'd0,  32'd4,   0, 16'h0000, 32'h00};
        vecs[6] = '{32'd67, 32'd8,  16, 16'h8080, 32'h3C};

        #2;
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_tx_cnt", tx_cnt, 32'd0);
        chk("rst_cti", 32'(wbm_cti_o), 32'd0);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("const_we", 32'(wbm_we_o), 32'd1);
        chk("const_sel", 32'(wbm_sel_o), 32'hF);
        chk("const_bte", 32'(wbm_bte_o), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 7; i++) begin
            start_adr = 32'h0000_4000 + 32'(i) * 32'h100;
            run_buffer(vecs[i].bsize, vecs[i].bst, vecs[i].beats, vecs[i].eob_mask, vecs[i].last_off);
        end

        // FIFO short of a full burst: controller waits with the bus idle.
        start_adr = 32'h0000_8000;
        setup(32'd16, 32'd4, 16'h0008, 3);
        ack_en = 1'b1;
        pulse_en();
        for (int i = 0; i < 4; i++) begin
            chk("wait_cyc", 32'(wbm_cyc_o), 32'd0);
            step();
        end
        chk("wait_busy", 32'(busy), 32'd1);
        wr_ptr = wr_ptr + 8'd1;
        chk("wait_cyc_same_cycle", 32'(wbm_cyc_o), 32'd0);
        step();
        chk("wait_cyc_rise", 32'(wbm_cyc_o), 32'd1);
        n = 0;
        while (irq_cnt == 0 && n < 50) begin step(); n++; end
        chk("wait_beats", 32'(beat_idx), 32'd4);

        // Retry on beat 0, two wait states on beat 2.
        start_adr = 32'h0000_9000;
        setup(32'd16, 32'd4, 16'h0008, 16);
        ack_en = 1'b0;
        pulse_en();
        n = 0;
        while (!wbm_cyc_o && n < 20) begin step(); n++; end
        chk("rty_cyc_up", 32'(wbm_cyc_o), 32'd1);
        a0 = wbm_adr_o; d0 = wbm_dat_o; r0 = rd_ptr;
        rty = 1'b1;
        step();
        chk("rty_adr_hold", wbm_adr_o, a0);
        chk("rty_dat_hold", wbm_dat_o, d0);
        chk("rty_no_pop", 32'(rd_ptr), 32'(r0));
        chk("rty_tx_cnt", tx_cnt, 32'd0);
        rty = 1'b0; ack_en = 1'b1;
        step(); step();
        ack_en = 1'b0;
        a0 = wbm_adr_o; d0 = wbm_dat_o;
        step(); step();
        chk("ws_adr_hold", wbm_adr_o, a0);
        chk("ws_dat_hold", wbm_dat_o, d0);
        chk("ws_tx_cnt", tx_cnt, 32'd2);
        chk("ws_pops", 32'(rd_ptr), 32'(r0 + 8'd2));
        ack_en = 1'b1;
        n = 0;
        while (irq_cnt == 0 && n < 50) begin step(); n++; end
        chk("rty_beats", 32'(beat_idx), 32'd4);
        chk("rty_irq", 32'(irq_cnt), 32'd1);

        // Asynchronous reset in the middle of the second burst.
        start_adr = 32'h0000_A000;
        setup(32'd64, 32'd4, 16'h8888, 16);
        ack_en = 1'b1;
        pulse_en();
        n = 0;
        while (tx_cnt != 32'd5 && n < 50) begin step(); n++; end
        chk("mid_tx_cnt", tx_cnt, 32'd5);
        chk("mid_cyc", 32'(wbm_cyc_o), 32'd1);
        rst_n = 1'b0;
        #2;
        chk("arst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("arst_stb", 32'(wbm_stb_o), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_tx_cnt", tx_cnt, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        run_buffer(32'd16, 32'd4, 4, 16'h0008, 32'h0C);

`ifdef WB_STREAM_READER_ERR_EN
        start_adr = 32'h0000_B000;
        setup(32'd64, 32'd4, 16'h8888, 16);
        ack_en = 1'b1;
        pulse_en();
        n = 0;
        while (tx_cnt != 32'd2 && n < 20) begin step(); n++; end
        ack_en = 1'b0; err_en = 1'b1; r0 = rd_ptr;
        step();
        err_en = 1'b0;
        chk("err_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("err_flag", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_tx_cnt", tx_cnt, 32'd2);
        chk("err_no_pop", 32'(rd_ptr), 32'(r0));
        step();
        chk("err_irq", 32'(irq_cnt), 32'd1);
        pulse_en();
        chk("err_cleared", 32'(err), 32'd0);
        chk("err_restart_busy", 32'(busy), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_stream_reader_ctrl.md
Name: wb_stream_reader_ctrl

Overview:
Wishbone burst-write master that drains a stream-input FIFO into a memory buffer. It is the memory-write counterpart of the stream writer path: FIFO data is written to a buffer at start_adr in linear incrementing bursts of up to burst_size words. It sits between the stream-in FIFO (show-ahead read side) and the system Wishbone interconnect. A CPU-facing register block drives the configuration interface.

Parameters:
WB_AW, 32, Wishbone address width
WB_DW, 32, Wishbone data width; byte lanes = WB_DW/8
FIFO_AW, 4, FIFO address width; FIFO depth = 2**FIFO_AW; must be > 0 (elaboration error otherwise)
MAX_BURST_LEN, 16, largest supported burst_size in words; sizes the burst counter

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous active-low reset
wbm_adr_o  out  WB_AW  byte address = start_adr + tx_cnt*4
wbm_dat_o  out  WB_DW  write data = fifo_d
wbm_sel_o  out  WB_DW/8  all ones
wbm_we_o  out  1  constant 1
wbm_cyc_o  out  1  high in S_BURST
wbm_stb_o  out  1  high in S_BURST
wbm_cti_o  out  3  000 idle, 010 burst beat, 111 final beat
wbm_bte_o  out  2  constant 00 (linear)
wbm_dat_i  in  WB_DW  unused
wbm_ack_i  in  1  beat accepted
wbm_err_i  in  1  bus error
wbm_rty_i  in  1  retry; treated as no ack
fifo_d  in  WB_DW  show-ahead FIFO head word
fifo_rd  out  1  FIFO pop = wbm_ack_i & wbm_cyc_o
fifo_cnt  in  FIFO_AW+1  words available in FIFO
enable  in  1  start-of-buffer request pulse
busy  out  1  buffer transfer in progress
irq  out  1  one-cycle pulse when buffer complete
tx_cnt  out  WB_AW  words written in current buffer
start_adr  in  WB_AW  buffer base byte address, word aligned
buf_size  in  WB_AW  buffer size in bytes; word count = buf_size[WB_AW-1:2]
burst_size  in  WB_AW  nominal burst length in words, 1..MAX_BURST_LEN

Behaviour:
- Reset (async, wb_rst_n_i low): state=S_IDLE, busy=0, irq=0, tx_cnt=0, burst counter=0, all Wishbone strobes 0, cti=000.
- Words remaining rem = buf_words - tx_cnt. Burst length blen = min(burst_size, rem), latched when entering S_BURST. burst_size=0 is treated as 1.
- FSM states:
  - S_IDLE: enable with buf_words != 0 sets busy=1 and tx_cnt=0, then goes to S_WAIT. enable with buf_words==0 is ignored.
  - S_WAIT: when fifo_cnt >= blen, go to S_BURST next cycle. No bus activity in this state.
  - S_BURST: cyc=stb=1. On each ack, tx_cnt+1 and burst counter+1. On the ack of the final beat (burst counter == blen-1), return to S_WAIT, or to S_IDLE if tx_cnt+1 == buf_words. Entering S_IDLE this way sets busy=0 and pulses irq high for exactly one cycle.
- wbm_cti_o is combinational from state and burst counter: 111 on the final beat of every burst, including blen=1.
- Address and data follow the current tx_cnt and FIFO head. Both are stable while stb=1 and no ack has occurred.
- rty or no response: the beat is held unchanged and there is no FIFO pop.
- enable while busy is ignored. Configuration inputs are sampled live; software must not change them while busy.
- The FIFO never underflows, because S_BURST is entered only when fifo_cnt >= blen.
- All arithmetic is WB_AW wide, unsigned, and wraps modulo 2**WB_AW.

Optional Feature:
Macro WB_STREAM_READER_ERR_EN.
- Defined:
  - wbm_err_i in S_BURST ends the cycle immediately: state goes to S_IDLE and busy=0.
  - Adds output err (1 bit). It is set sticky on the error and cleared on the next accepted enable.
  - irq pulses on abort as well.
  - tx_cnt freezes at the failing word index, with no increment and no FIFO pop.
- Undefined: wbm_err_i is ignored and the beat stalls like rty. The err port is absent.

Decomposition:
- Package wb_stream_pkg holds:
  - state encoding localparams S_IDLE=0, S_WAIT=1, S_BURST=2
  - CTI constants CTI_CLASSIC=000, CTI_INC=010, CTI_EOB=111
  - the BTE_LINEAR=00 constant
- No sub-module is needed. The burst-length min() and remaining-word computation stay inline in one combinational block.

Test Plan:
- buf_size=64, burst_size=4, FIFO preloaded with 16 words, ack every cycle -> 4 bursts at start_adr+0x00/0x10/0x20/0x30; cti 010,010,010,111 per burst; irq once; busy falls; tx_cnt=16.
- buf_size=40 (10 words), burst_size=4 -> bursts of 4, 4, 2; the final burst has cti 010,111; the last address is start_adr+0x24.
- fifo_cnt=3, burst_size=4 -> stays in S_WAIT with cyc=0. When fifo_cnt reaches 4, cyc rises the next cycle.
- Slave inserts rty then ack, plus 2 wait states on beat 2 -> adr/dat held stable; fifo_rd only on ack; data order preserved.
- Pull wb_rst_n_i low mid-burst (tx_cnt=5) -> cyc/stb/busy drop asynchronously, tx_cnt=0; a new enable restarts from start_adr.
- With WB_STREAM_READER_ERR_EN, err on beat 3 of the first burst -> cyc drops, err=1, busy=0, irq pulse, tx_cnt=2; the next enable clears err.
